// File: rtl/neuron_pool_tmux.sv
// neuron_pool_tmux: NUM_NEURON leaky integrate-and-fire neurons, one updated per rawclk; results publish NUM_NEURON+1 cycles after tick.
// No backpressure: a tick during a sweep is dropped and latches overrun. Define REFRACTORY_EN for per-neuron refractory counters.
module neuron_pool_tmux #(
    parameter int          NN         = 6,
    parameter int          W          = 18,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] LFSR_SEED  = 32'h1234_5678,
    parameter int          REF_W      = 4,
    localparam int         NUM_NEURON = 2 ** (NN + 1)
) (
    input  logic                  rawclk,
    input  logic                  reset_global,
    input  logic [31:0]           half_cnt,
    input  logic signed [W-1:0]   i_drive,
    input  logic [7:0]            noise_amp,
    input  logic [3:0]            leak_shift,
    input  logic signed [W-1:0]   th,
    input  logic [REF_W-1:0]      ref_ticks,
    output logic                  tick,
    output logic                  busy,
    output logic                  each_spike,
    output logic [15:0]           spkid,
    output logic [NUM_NEURON-1:0] population,
    output logic                  spike,
    output logic [CNT_W-1:0]      spike_count,
    output logic                  overrun
);
    localparam int IW = NN + 1;
    localparam int XW = W + 10;
    localparam logic signed [XW-1:0] P_MAX     = XW'((2 ** (W - 1)) - 1);
    localparam logic signed [XW-1:0] P_MIN     = ~P_MAX;
    localparam logic [31:0]          LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state;
    logic [32:0]           r_div;
    logic [IW-1:0]         r_idx;
    logic [31:0]           r_lfsr;
    logic signed [W-1:0]   r_mem [NUM_NEURON];
    logic [NUM_NEURON-1:0] r_shadow;
    logic [CNT_W-1:0]      r_shadow_cnt;
    logic                  r_tick;
    logic                  r_busy;
    logic                  r_each_spike;
    logic                  r_spike;
    logic                  r_overrun;
    logic [15:0]           r_spkid;
    logic [NUM_NEURON-1:0] r_population;
    logic [CNT_W-1:0]      r_spike_count;

    logic                  w_wrap;
    logic                  w_fire;
    logic                  w_refr;
    logic signed [W-1:0]   w_v;
    logic signed [W-1:0]   w_v_sat;
    logic signed [W-1:0]   w_v_next;
    logic signed [15:0]    w_noise;
    logic signed [XW-1:0]  w_sum;

    // The divider wraps at 2*half_cnt+1, which is also the sweep start event.
    assign w_wrap  = (r_div == {half_cnt, 1'b1});
    assign w_v     = r_mem[r_idx];
    assign w_noise = $signed({{8{r_lfsr[7]}}, r_lfsr[7:0]}) * $signed({8'd0, noise_amp});
    assign w_sum   = XW'(w_v) - XW'(w_v >>> leak_shift) + XW'(i_drive) + XW'(w_noise);

    always_comb begin
        w_v_sat = w_sum[W-1:0];
        if (w_sum > P_MAX) begin
            w_v_sat = P_MAX[W-1:0];
        end else if (w_sum < P_MIN) begin
            w_v_sat = P_MIN[W-1:0];
        end
    end

`ifdef REFRACTORY_EN
    logic [REF_W-1:0] r_ref [NUM_NEURON];

    assign w_refr = (r_ref[r_idx] != '0);

    always_ff @(posedge rawclk) begin
        if (reset_global) begin
            for (int i = 0; i < NUM_NEURON; i++) r_ref[i] <= '0;
        end else if (r_state == S_RUN) begin
            if (w_fire) begin
                r_ref[r_idx] <= ref_ticks;
            end else if (w_refr) begin
                r_ref[r_idx] <= r_ref[r_idx] - 1'b1;
            end
        end
    end
`else
    logic w_ref_unused;
    assign w_refr       = 1'b0;
    assign w_ref_unused = ^ref_ticks;
`endif

    assign w_fire   = !w_refr && (w_v_sat >= th);
    assign w_v_next = (w_fire || w_refr) ? '0 : w_v_sat;

    always_ff @(posedge rawclk) begin
        if (reset_global) begin
            r_state       <= S_IDLE;
            r_div         <= '0;
            r_idx         <= '0;
            r_lfsr        <= LFSR_SEED;
            r_shadow      <= '0;
            r_shadow_cnt  <= '0;
            r_tick        <= 1'b0;
            r_busy        <= 1'b0;
            r_each_spike  <= 1'b0;
            r_spike       <= 1'b0;
            r_overrun     <= 1'b0;
            r_spkid       <= '0;
            r_population  <= '0;
            r_spike_count <= '0;
            for (int i = 0; i < NUM_NEURON; i++) r_mem[i] <= '0;
        end else begin
            r_div        <= w_wrap ? '0 : r_div + 33'd1;
            r_tick       <= w_wrap;
            r_each_spike <= 1'b0;
            if (w_wrap && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_wrap) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_mem[r_idx] <= w_v_next;
                    r_lfsr       <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 32'd0);
                    if (w_fire) begin
                        r_each_spike    <= 1'b1;
                        r_spkid         <= 16'(r_idx);
                        r_shadow[r_idx] <= 1'b1;
                        r_shadow_cnt    <= r_shadow_cnt + 1'b1;
                    end
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IW'(NUM_NEURON - 1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_population  <= r_shadow;
                    r_spike_count <= r_shadow_cnt;
                    r_spike       <= |r_shadow;
                    r_shadow      <= '0;
                    r_shadow_cnt  <= '0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tick        = r_tick;
    assign busy        = r_busy;
    assign each_spike  = r_each_spike;
    assign spkid       = r_spkid;
    assign population  = r_population;
    assign spike       = r_spike;
    assign spike_count = r_spike_count;
    assign overrun     = r_overrun;
endmodule
